zincir_sifreleme: RTL

ZINCIR_SIFRELEME -- requirements
Module: zincir_sifreleme

---
 rtl/sifreleme_pkg.sv | 52 +++++
 rtl/sifreleme_asama.sv | 79 +++++++
 rtl/zincir_sifreleme.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sifreleme_pkg.sv
// Shared definitions for the cascaded cipher chain.
//   - OP_* op-code constants (3-bit, values 0..7)
//   - durum_e: per-stage serialiser state
//   - sifrele(): one cipher op on a word of run-time width n (n <= 32)
package sifreleme_pkg;

  localparam logic [2:0] OP_ROL  = 3'd0;  // enc rotl1 / dec rotr1
  localparam logic [2:0] OP_ROR  = 3'd1;  // enc rotr1 / dec rotl1
  localparam logic [2:0] OP_XOR  = 3'd2;  // XOR key
  localparam logic [2:0] OP_NOT  = 3'd3;  // bitwise NOT
  localparam logic [2:0] OP_TERS = 3'd4;  // bit reverse
  localparam logic [2:0] OP_YARI = 3'd5;  // swap halves
  localparam logic [2:0] OP_ART  = 3'd6;  // enc +1 / dec -1
  localparam logic [2:0] OP_GEC  = 3'd7;  // pass

  typedef enum logic {
    BOS,     // idle, waiting for a load
    GONDER   // shifting bits out
  } durum_e;

  // Word arrives zero-extended to 32 bits; result is masked to n bits.
  function automatic logic [31:0] sifrele(input logic [31:0] w,
                                          input logic [2:0]  op,
                                          input logic        coz,
                                          input int unsigned n,
                                          input logic [31:0] anahtar);
    logic [31:0] m;
    logic [31:0] r;
    logic        sol;
    m   = (32'd1 << n) - 32'd1;  // shift of 32 yields 0, so mask is all ones
    r   = '0;
    sol = (op == OP_ROL) ? ~coz : coz;
    case (op)
      OP_ROL, OP_ROR: begin
        if (sol) r = ((w << 1) | (w >> (n - 1))) & m;
        else     r = ((w >> 1) | (w << (n - 1))) & m;
      end
      OP_XOR:  r = (w ^ anahtar) & m;
      OP_NOT:  r = ~w & m;
      OP_TERS: begin
        for (int unsigned i = 0; i < 32; i++) begin
          if (i < n) r[i] = w[n - 1 - i];
        end
      end
      OP_YARI: r = ((w >> (n / 2)) | (w << (n / 2))) & m;
      OP_ART:  r = (coz ? (w - 32'd1) : (w + 32'd1)) & m;
      default: r = w & m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sifreleme_asama.sv
// One cipher stage: on yukle_i it applies op_i (mode mod_i) to veri_i and
// then shifts the result out LSB first, one bit per cycle, with gecerli_o
// high throughout. With PARITE=1 one extra even-parity bit follows bit BIT-1.
// Ports:
//   saat, reset         clock, synchronous active-high reset
//   yukle_i             one-cycle load pulse (ignored while shifting)
//   mod_i, op_i, veri_i mode, op code and input word, sampled with yukle_i
//   bit_o, gecerli_o    serial bit (0 when not valid) and its valid
module sifreleme_asama
  import sifreleme_pkg::*;
#(
  parameter int unsigned    BIT     = 8,
  parameter logic [BIT-1:0] ANAHTAR = 8'hA5,
  parameter bit             PARITE  = 1'b0
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           yukle_i,
  input  logic           mod_i,
  input  logic [2:0]     op_i,
  input  logic [BIT-1:0] veri_i,
  output logic           bit_o,
  output logic           gecerli_o
);

  localparam int unsigned SW  = $clog2(BIT + 1);
  localparam int unsigned SON = BIT - 1 + (PARITE ? 1 : 0);

  durum_e         durum_q, durum_d;
  logic [BIT-1:0] sr_q, sr_d;
  logic [SW-1:0]  sayac_q, sayac_d;
  logic           par_q, par_d;
  logic           parite_faz;

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q <= BOS;
      sr_q    <= '0;
      sayac_q <= '0;
      par_q   <= 1'b0;
    end else begin
      durum_q <= durum_d;
      sr_q    <= sr_d;
      sayac_q <= sayac_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    sr_d    = sr_q;
    sayac_d = sayac_q;
    par_d   = par_q;
    unique case (durum_q)
      BOS: begin
        if (yukle_i) begin
          sr_d    = BIT'(sifrele(32'(veri_i), op_i, mod_i, BIT, 32'(ANAHTAR)));
          par_d   = ^sr_d;
          sayac_d = '0;
          durum_d = GONDER;
        end
      end
      GONDER: begin
        if (sayac_q == SW'(SON)) begin
          durum_d = BOS;
        end else begin
          sayac_d = sayac_q + 1'b1;
          sr_d    = sr_q >> 1;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  assign parite_faz = PARITE && (sayac_q == SW'(BIT));
  assign gecerli_o  = (durum_q == GONDER);
  assign bit_o      = gecerli_o & (parite_faz ? par_q : sr_q[0]);

endmodule

// File: rtl/zincir_sifreleme.sv
// Cascaded cipher chain: ASAMA serial stages; each intermediate stage's bits
// are collected back into a word that, one cycle later, loads the next stage.
// Stage k runs in mode mod ^ (k mod 2) with op secim[3k+2:3k].
// Optional: define ZINCIR_PARITE_EN to append an even-parity bit to the
// final stage's output (gecerli/mesgul stretched by one cycle).
// Ports:
//   saat, reset        clock, synchronous active-high reset
//   basla              start request, accepted only when mesgul=0
//   mod, veri, secim   mode, plaintext, per-stage op selects (sampled w/ basla)
//   bit_cikisi         final-stage serial bit, LSB first (0 when not valid)
//   gecerli            bit_cikisi valid
//   mesgul             chain busy
module zincir_sifreleme
  import sifreleme_pkg::*;
#(
  parameter int unsigned    BIT     = 8,
  parameter int unsigned    ASAMA   = 2,
  parameter logic [BIT-1:0] ANAHTAR = 8'hA5
) (
  input  logic             saat,
  input  logic             reset,
  input  logic             basla,
  input  logic             mod,
  input  logic [BIT-1:0]   veri,
  input  logic [3*ASAMA-1:0] secim,
  output logic             bit_cikisi,
  output logic             gecerli,
  output logic             mesgul
);

`ifdef ZINCIR_PARITE_EN
  localparam bit PARITE = 1'b1;
`else
  localparam bit PARITE = 1'b0;
`endif

  localparam int unsigned CW = $clog2(BIT);

  logic                 kabul;
  logic                 mesgul_w;
  logic [ASAMA-1:0]     yukle, md, s_bit, s_vld, ara_basla;
  logic [ASAMA*BIT-1:0] girdi;
  logic [3*ASAMA-1:0]   opk;

  assign kabul        = basla & ~mesgul_w;
  assign ara_basla[0] = 1'b0;
  assign yukle[0]     = kabul;
  assign md[0]        = mod;
  assign opk[2:0]     = secim[2:0];
  assign girdi[BIT-1:0] = veri;

  generate
    if (ASAMA > 1) begin : g_zincir
      // Ops and mode for the later stages are held for the whole word.
      logic [3*ASAMA-4:0] secim_q;
      logic               mod_q;

      always_ff @(posedge saat) begin
        if (reset) begin
          secim_q <= '0;
          mod_q   <= 1'b0;
        end else if (kabul) begin
          secim_q <= secim[3*ASAMA-1:3];
          mod_q   <= mod;
        end
      end

      for (genvar k = 1; k < ASAMA; k++) begin : g_ara
        logic [BIT-1:0] topla_q;
        logic [CW-1:0]  sayac_q;
        logic           bas_q;

        // The start pulse is registered on capture of the last bit, so the
        // next stage loads a complete word one cycle later.
        always_ff @(posedge saat) begin
          if (reset) begin
            topla_q <= '0;
            sayac_q <= '0;
            bas_q   <= 1'b0;
          end else begin
            bas_q <= 1'b0;
            if (s_vld[k-1]) begin
              topla_q[sayac_q] <= s_bit[k-1];
              if (sayac_q == CW'(BIT - 1)) begin
                sayac_q <= '0;
                bas_q   <= 1'b1;
              end else begin
                sayac_q <= sayac_q + 1'b1;
              end
            end
          end
        end

        assign ara_basla[k]        = bas_q;
        assign yukle[k]            = bas_q;
        assign girdi[k*BIT +: BIT] = topla_q;
        assign opk[3*k +: 3]       = secim_q[3*(k-1) +: 3];
        assign md[k]               = mod_q ^ 1'(k % 2);
      end
    end

    for (genvar k = 0; k < ASAMA; k++) begin : g_asama
      sifreleme_asama #(
        .BIT     (BIT),
        .ANAHTAR (ANAHTAR),
        .PARITE  ((k == ASAMA - 1) ? PARITE : 1'b0)
      ) u_asama (
        .saat      (saat),
        .reset     (reset),
        .yukle_i   (yukle[k]),
        .mod_i     (md[k]),
        .op_i      (opk[3*k +: 3]),
        .veri_i    (girdi[k*BIT +: BIT]),
        .bit_o     (s_bit[k]),
        .gecerli_o (s_vld[k])
      );
    end
  endgenerate

  // Busy covers every stage's shifting and every inter-stage gap cycle.
  always_comb begin
    mesgul_w = (|s_vld) | (|ara_basla);
  end

  assign bit_cikisi = s_bit[ASAMA-1];
  assign gecerli    = s_vld[ASAMA-1];
  assign mesgul     = mesgul_w;

endmodule
